adrv9001_spi_responder: RTL and testbench
=========================================

// Module: adrv9001_spi_responder
// PURPOSE
//  Synthesizable SPI target that emulates the ADRV9001 SPI port. It lets the
//  SPI initiator in the system block (adrv9001_spi_clk/mosi/miso/csn) run in
//  loopback and hardware bring-up without a transceiver attached. SPI pins are
//  oversampled in the clk domain. The block decodes the 16-bit instruction
//  (bit15 = R/W, 1 = read; bits14:0 = address), then streams 8-bit data bytes
//  with address auto-increment, backed by a byte register file.
// PARAMETERS
//  ADDR_WIDTH   8  register-file depth is 2**ADDR_WIDTH bytes; higher addresses are out of range
//  SYNC_STAGES  2  synchronizer flops on spi_clk, spi_csn and spi_mosi (minimum 2)
// PORTS
//  clk           in   1   system clock; all logic is single-clock
//  rstn          in   1   asynchronous active-low reset
//  spi_clk       in   1   SPI clock from initiator; CPOL=0, CPHA=0
//  spi_csn       in   1   chip select, active low
//  spi_mosi      in   1   serial data from initiator
//  spi_miso      out  1   serial data to initiator
//  spi_miso_t    out  1   tristate for spi_miso; 1 = high-Z
//  reg_wr_valid  out  1   one-cycle pulse per SPI byte written to the register file
//  reg_wr_addr   out  15  address of that write
//  reg_wr_data   out  8   data of that write
//  host_wr_en    in   1   local write into the register file (status injection)
//  host_wr_addr  in   ADDR_WIDTH  local write address
//  host_wr_data  in   8   local write data
//  host_wr_drop  out  1   one-cycle pulse when a host write loses to an SPI write
//  busy          out  1   1 while csn is asserted (synchronized)
//  err           out  1   sticky: out-of-range access seen; cleared by err_clr
//  err_clr       in   1   clears err; a simultaneous new error leaves err at 1
// BEHAVIOUR
//  - Reset values: spi_miso=0, spi_miso_t=1, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0,
//    host_wr_drop=0, busy=0, err=0, FSM=IDLE. Register-file contents are not reset.
//  - Edge detection: rise/fall are taken from the last two synchronized spi_clk samples.
//    spi_clk high and low times must each be >= SYNC_STAGES+2 clk cycles.
//  - FSM states and transitions:
//      IDLE:  csn falls -> INSTR, bit_cnt=0, spi_miso_t=0.
//      INSTR: each rise shifts mosi MSB-first into instr[15:0]. On the 16th rise, latch
//             rw=instr[15] and addr=instr[14:0]. If rw=1, load tx_shift=mem[addr]
//             (0x00 if out of range) -> DATA, bit_cnt=0.
//      DATA:  each rise shifts mosi into rx_byte. On the 8th rise:
//             write (rw=0): mem[addr]=rx_byte, pulse reg_wr_valid for 1 cycle.
//             Then addr=addr+1 with 15-bit wrap (0x7FFF -> 0x0000). If rw=1, reload
//             tx_shift from the new addr. bit_cnt=0. Stay in DATA.
//      any state: csn rises -> IDLE, spi_miso_t=1. A partial byte is discarded and
//             nothing is written.
//  - MISO: spi_miso = tx_shift[7]. Each fall in DATA with bit_cnt != 0 shifts tx_shift
//    left. A fall with bit_cnt == 0 (just loaded) does not shift, so the MSB of each
//    byte is valid before the first data rise. In write transactions spi_miso is 0.
//  - Out of range (addr >= 2**ADDR_WIDTH): the write is dropped and no reg_wr_valid
//    pulse is issued; a read returns 0x00. Both set err. addr still increments.
//  - reg_wr_valid is asserted 1 clk after the clk in which the 8th rise is detected.
//  - Simultaneous SPI write and host write in the same cycle: the SPI write wins, the
//    host write is dropped, and host_wr_drop pulses, including when the addresses differ.
//  - csn asserted with spi_clk high at the csn fall: that level is not treated as a
//    rise; only rises after the csn fall count.
//  - An async reset mid-transfer forces the reset values immediately. The next
//    transaction requires a fresh csn fall.
// TESTING
//  1. Write 0x0010 <- 0xA5 (instr 0x0010, data 0xA5) -> one reg_wr_valid, addr 0x0010,
//     data 0xA5; readback (instr 0x8010) returns 0xA5 on MISO.
//  2. Streaming write at 0x00FE of bytes 0x11,0x22,0x33 (ADDR_WIDTH=8) -> writes to
//     0xFE and 0xFF, third byte dropped, err=1; err_clr then err=0.
//  3. host_wr 0x05 <- 0x3C, then SPI read 0x8005 for 2 bytes -> MISO 0x3C, then mem[0x06].
//  4. csn deasserted after 4 data bits of a write to 0x20 -> no reg_wr_valid, mem[0x20]
//     unchanged, spi_miso_t=1 within SYNC_STAGES+2 clks.
//  5. host_wr_en in the same cycle as the SPI write to 0x30 -> mem[0x30] holds the SPI
//     data and host_wr_drop pulses once.
//  6. Assert rstn low mid-read -> spi_miso_t=1 and busy=0 at once; the next full read
//     succeeds.

Source files
------------

// File: rtl/adrv9001_spi_responder.sv
// SPI target emulating the ADRV9001 register port: 16-bit instruction, then
// auto-incrementing 8-bit data bytes backed by a local byte register file.
module adrv9001_spi_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  spi_clk,
    input  logic                  spi_csn,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_t,
    output logic                  reg_wr_valid,
    output logic [14:0]           reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [7:0]            host_wr_data,
    output logic                  host_wr_drop,
    output logic                  busy,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_csn_sync, r_mosi_sync;
    logic                   r_clk_prev, r_csn_prev;
    logic [7:0]             r_mem [2**ADDR_WIDTH];

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [14:0] r_instr;
    logic [6:0]  r_rx;
    logic        r_rw;
    logic [14:0] r_addr;
    logic [7:0]  r_tx;
    logic        r_miso_t, r_busy, r_wr_valid, r_drop, r_err;
    logic [14:0] r_wr_addr;
    logic [7:0]  r_wr_data;

    logic        w_clk_s, w_csn_s, w_mosi_s;
    logic        w_rise, w_fall, w_csn_fall;
    logic [15:0] w_instr_next;
    logic [7:0]  w_rx_next;
    logic [14:0] w_addr_inc, w_rd_addr;
    logic        w_rd_oor, w_wr_oor;
    logic [7:0]  w_mem_rd;
    logic        w_instr_done, w_byte_done, w_spi_we, w_err_set;

    // csn chain resets to "asserted" so a transfer only starts after csn is seen high then low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_clk_sync  <= '0;
            r_csn_sync  <= '0;
            r_mosi_sync <= '0;
            r_clk_prev  <= 1'b0;
            r_csn_prev  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_clk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_clk_prev  <= w_clk_s;
            r_csn_prev  <= w_csn_s;
        end
    end

    always_comb begin
        w_clk_s      = r_clk_sync[SYNC_STAGES-1];
        w_csn_s      = r_csn_sync[SYNC_STAGES-1];
        w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
        w_rise       = w_clk_s & ~r_clk_prev;
        w_fall       = ~w_clk_s & r_clk_prev;
        w_csn_fall   = r_csn_prev & ~w_csn_s;
        w_instr_next = {r_instr, w_mosi_s};
        w_rx_next    = {r_rx, w_mosi_s};
        w_addr_inc   = r_addr + 15'd1;
        w_rd_addr    = (r_state == ST_INSTR) ? w_instr_next[14:0] : w_addr_inc;
        w_rd_oor     = (w_rd_addr >> ADDR_WIDTH) != 15'd0;
        w_wr_oor     = (r_addr >> ADDR_WIDTH) != 15'd0;
        w_mem_rd     = w_rd_oor ? 8'h00 : r_mem[w_rd_addr[ADDR_WIDTH-1:0]];
        w_instr_done = (r_state == ST_INSTR) & w_rise & ~w_csn_s & (r_bit_cnt == 4'd15);
        w_byte_done  = (r_state == ST_DATA) & w_rise & ~w_csn_s & (r_bit_cnt == 4'd7);
        w_spi_we     = w_byte_done & ~r_rw & ~w_wr_oor;
        w_err_set    = (w_byte_done & (r_rw ? w_rd_oor : w_wr_oor))
                     | (w_instr_done & w_instr_next[15] & w_rd_oor);
    end

    // SPI write has priority over the host port
    always_ff @(posedge clk) begin
        if (w_spi_we)
            r_mem[r_addr[ADDR_WIDTH-1:0]] <= w_rx_next;
        else if (host_wr_en)
            r_mem[host_wr_addr] <= host_wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_instr    <= '0;
            r_rx       <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_tx       <= '0;
            r_miso_t   <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_drop     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_valid <= w_spi_we;
            r_drop     <= w_spi_we & host_wr_en;
            r_err      <= (r_err & ~err_clr) | w_err_set;
            if (w_spi_we) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_next;
            end
            if (w_csn_s) begin
                r_state  <= ST_IDLE;
                r_miso_t <= 1'b1;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csn_fall) begin
                            r_state   <= ST_INSTR;
                            r_bit_cnt <= '0;
                            r_miso_t  <= 1'b0;
                            r_busy    <= 1'b1;
                            r_tx      <= '0;
                        end
                    end
                    ST_INSTR: begin
                        if (w_rise) begin
                            r_instr   <= w_instr_next[14:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_instr_done) begin
                                r_rw      <= w_instr_next[15];
                                r_addr    <= w_instr_next[14:0];
                                r_tx      <= w_instr_next[15] ? w_mem_rd : 8'h00;
                                r_bit_cnt <= '0;
                                r_state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_rise) begin
                            r_rx      <= w_rx_next[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (w_byte_done) begin
                                r_addr    <= w_addr_inc;
                                r_bit_cnt <= '0;
                                if (r_rw)
                                    r_tx <= w_mem_rd;
                            end
                        end else if (w_fall && r_bit_cnt != 4'd0) begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_miso     = r_tx[7];
    assign spi_miso_t   = r_miso_t;
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign host_wr_drop = r_drop;
    assign busy         = r_busy;
    assign err          = r_err;

endmodule

// File: tb/tb_adrv9001_spi_responder.sv
// Directed bench for adrv9001_spi_responder: vector table of SPI transactions
// plus hand sequences for host collision, aborted bytes and async reset.
module tb_adrv9001_spi_responder;

    localparam int AW = 8;
    localparam int SS = 2;
    localparam int H  = 6;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_t, reg_wr_valid, host_wr_drop, busy, err;
    logic [14:0]   reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic          host_wr_en = 1'b0, err_clr = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [7:0]    host_wr_data = '0;

    int n_cmp = 0, n_bad = 0;
    int wr_cnt = 0, drop_cnt = 0;
    logic [14:0] last_addr = '0;
    logic [7:0]  last_data = '0;

    always #5 clk = ~clk;

    adrv9001_spi_responder #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rstn(rstn), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_t(spi_miso_t),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_drop(host_wr_drop), .busy(busy), .err(err), .err_clr(err_clr)
    );

    always @(negedge clk) begin
        if (reg_wr_valid) begin
            wr_cnt    = wr_cnt + 1;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
        if (host_wr_drop) drop_cnt = drop_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input bit collide, output logic m);
        spi_mosi = b;
        repeat (H) @(negedge clk);
        m = spi_miso;
        spi_clk = 1'b1;
        if (collide) begin
            repeat (SS) @(negedge clk);
            host_wr_en = 1'b1;
            @(negedge clk);
            host_wr_en = 1'b0;
            repeat (H - SS - 1) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        spi_clk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] instr, input int nbytes, input logic [23:0] wd,
                            input int collide_byte, output logic [23:0] rd);
        logic m;
        rd = '0;
        spi_csn = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], 1'b0, m);
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(wd[16 - 8*b + i], (b == collide_byte) && (i == 0), m);
                rd[16 - 8*b + i] = m;
            end
        end
        repeat (H) @(negedge clk);
        spi_csn = 1'b1;
        repeat (2*H) @(negedge clk);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] instr;
        int          nbytes;
        logic [23:0] wd;
        logic [23:0] exp_rd;
        int          exp_wr;
        logic [14:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vec[9];

    initial begin
        logic [23:0] rd;
        logic        m;
        int          w0, d0;

        vec[0] = '{16'h0010, 1, 24'hA50000, 24'h000000, 1, 15'h0010, 8'hA5, 1'b0};
        vec[1] = '{16'h8010, 1, 24'h000000, 24'hA50000, 0, 15'h0000, 8'h00, 1'b0};
        vec[2] = '{16'h0040, 2, 24'h5AC300, 24'h000000, 2, 15'h0041, 8'hC3, 1'b0};
        vec[3] = '{16'h8040, 2, 24'h000000, 24'h5AC300, 0, 15'h0000, 8'h00, 1'b0};
        vec[4] = '{16'h00FE, 3, 24'h112233, 24'h000000, 2, 15'h00FF, 8'h22, 1'b1};
        vec[5] = '{16'h80FE, 3, 24'h000000, 24'h112200, 0, 15'h0000, 8'h00, 1'b1};
        vec[6] = '{16'h7FFF, 2, 24'h778800, 24'h000000, 1, 15'h0000, 8'h88, 1'b1};
        vec[7] = '{16'h8000, 1, 24'h000000, 24'h880000, 0, 15'h0000, 8'h00, 1'b0};
        vec[8] = '{16'h8100, 1, 24'h000000, 24'h000000, 0, 15'h0000, 8'h00, 1'b1};

        repeat (3) @(negedge clk);
        check("rst miso",     spi_miso,     1'b0);
        check("rst miso_t",   spi_miso_t,   1'b1);
        check("rst wr_valid", reg_wr_valid, 1'b0);
        check("rst wr_addr",  reg_wr_addr,  15'h0);
        check("rst wr_data",  reg_wr_data,  8'h0);
        check("rst drop",     host_wr_drop, 1'b0);
        check("rst busy",     busy,         1'b0);
        check("rst err",      err,          1'b0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            w0 = wr_cnt;
            spi_xfer(vec[i].instr, vec[i].nbytes, vec[i].wd, -1, rd);
            check($sformatf("v%0d wr_count", i), wr_cnt - w0, vec[i].exp_wr);
            if (vec[i].exp_wr > 0) begin
                check($sformatf("v%0d wr_addr", i), last_addr, vec[i].exp_addr);
                check($sformatf("v%0d wr_data", i), last_data, vec[i].exp_data);
            end
            check($sformatf("v%0d miso", i), rd, vec[i].exp_rd);
            check($sformatf("v%0d err", i), err, vec[i].exp_err);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d err_clr", i), err, 1'b0);
        end

        // host writes then a two-byte SPI read
        host_write(8'h05, 8'h3C);
        host_write(8'h06, 8'h7E);
        w0 = wr_cnt;
        spi_xfer(16'h8005, 2, 24'h0, -1, rd);
        check("host rd", rd, 24'h3C7E00);
        check("host rd wr_count", wr_cnt - w0, 0);

        // csn released after 4 data bits of a write
        spi_xfer(16'h0020, 1, 24'h990000, -1, rd);
        w0 = wr_cnt;
        spi_csn = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 15; i >= 0; i--) spi_bit(i == 5, 1'b0, m);
        for (int i = 0; i < 4; i++) spi_bit(i[0], 1'b0, m);
        repeat (H) @(negedge clk);
        check("abort miso_t active", spi_miso_t, 1'b0);
        check("abort busy active", busy, 1'b1);
        spi_csn = 1'b1;
        repeat (SS + 2) @(posedge clk);
        #1;
        check("abort miso_t", spi_miso_t, 1'b1);
        repeat (2*H) @(negedge clk);
        check("abort wr_count", wr_cnt - w0, 0);
        spi_xfer(16'h8020, 1, 24'h0, -1, rd);
        check("abort mem", rd, 24'h990000);

        // host write colliding with SPI write
        host_wr_addr = 8'h30;
        host_wr_data = 8'hEE;
        w0 = wr_cnt;
        d0 = drop_cnt;
        spi_xfer(16'h0030, 1, 24'h5A0000, 0, rd);
        check("coll drop", drop_cnt - d0, 1);
        check("coll wr_count", wr_cnt - w0, 1);
        spi_xfer(16'h8030, 1, 24'h0, -1, rd);
        check("coll mem", rd, 24'h5A0000);

        // async reset in the middle of a read
        w0 = wr_cnt;
        spi_csn = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 15; i >= 0; i--) spi_bit(i == 15 || i == 4, 1'b0, m);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, m);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst mid miso_t", spi_miso_t, 1'b1);
        check("rst mid busy", busy, 1'b0);
        check("rst mid miso", spi_miso, 1'b0);
        repeat (2) @(negedge clk);
        spi_csn = 1'b1;
        rstn = 1'b1;
        repeat (2*H) @(negedge clk);
        spi_xfer(16'h8010, 1, 24'h0, -1, rd);
        check("rst after rd", rd, 24'hA50000);
        check("rst after wr_count", wr_cnt - w0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
